// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: Galois/Fibonacci LFSR word source on a valid/ready stream with hardware period measurement
module lfsr_stream_gen #(
    parameter int W = 8,
    parameter int MODE = 0,
    parameter logic [W-1:0] TAPS = W'(8'hB8),
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] seed_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] q,
    output logic         bit_out,
    output logic         wrap,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         seed_err
);
    logic [W-1:0] start_word;
    logic [W-1:0] count;
    logic [W-1:0] nxt;
    logic [W-1:0] load_word;
    logic         xfer;

    if (W < 3 || W > 32 || SEED == '0 || (MODE != 0 && MODE != 1) ||
        (MODE == 0 && !TAPS[W-1]) || (MODE == 1 && !TAPS[0])) begin : g_param_check
        $error("lfsr_stream_gen: illegal W/MODE/TAPS/SEED combination");
    end

    always_comb begin
        nxt = (MODE == 1) ? {^(q & TAPS), q[W-1:1]} : ((q >> 1) ^ (q[0] ? TAPS : '0));
        load_word = (seed_in == '0) ? SEED : seed_in;
        xfer = out_valid && out_ready;
        bit_out = q[0];
    end

    // load outranks a transfer; wrap compares the next word so the pulse lines up with q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q            <= SEED;
            start_word   <= SEED;
            out_valid    <= 1'b0;
            wrap         <= 1'b0;
            seed_err     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            count        <= '0;
        end else begin
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                q            <= load_word;
                start_word   <= load_word;
                out_valid    <= 1'b0;
                seed_err     <= (seed_in == '0);
                period       <= '0;
                period_valid <= 1'b0;
                count        <= '0;
            end else if (xfer) begin
                q         <= nxt;
                out_valid <= en;
                if (nxt == start_word) begin
                    wrap         <= 1'b1;
                    period       <= count + 1'b1;
                    period_valid <= 1'b1;
                    count        <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (!out_valid && en) begin
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed checks of Galois and Fibonacci LFSR stream generators
module tb_lfsr_stream_gen;
    logic       clk = 1'b0;
    logic       reset, en, load, out_ready;
    logic [7:0] seed_in;
    logic       g_out_valid, g_bit_out, g_wrap, g_period_valid, g_seed_err;
    logic [7:0] g_q, g_period;
    logic       f_out_valid, f_bit_out, f_wrap, f_period_valid, f_seed_err;
    logic [7:0] f_q, f_period;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_stream_gen #(.W(8), .MODE(0), .TAPS(8'hB8), .SEED(8'h01)) u_gal (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
        .out_ready(out_ready), .out_valid(g_out_valid), .q(g_q), .bit_out(g_bit_out),
        .wrap(g_wrap), .period(g_period), .period_valid(g_period_valid), .seed_err(g_seed_err)
    );

    lfsr_stream_gen #(.W(8), .MODE(1), .TAPS(8'h1D), .SEED(8'h01)) u_fib (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
        .out_ready(out_ready), .out_valid(f_out_valid), .q(f_q), .bit_out(f_bit_out),
        .wrap(f_wrap), .period(f_period), .period_valid(f_period_valid), .seed_err(f_seed_err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b0; out_ready = 1'b1; seed_in = 8'h00;
        step(); step();
        n_tests++; if (g_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", g_out_valid); end
        n_tests++; if (g_q !== 8'h01) begin n_fail++; $display("FAIL reset_q: got %h expected 01", g_q); end
        n_tests++; if (g_period !== 8'h00 || g_period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_period: got %h/%b expected 00/0", g_period, g_period_valid); end
        n_tests++; if (g_wrap !== 1'b0 || g_seed_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b expected 0/0", g_wrap, g_seed_err); end
        reset = 1'b0;
    endtask

    task automatic test_galois_seq();
        logic [7:0] exp [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++; if (g_q !== exp[i] || g_out_valid !== 1'b1) begin n_fail++; $display("FAIL galois_word%0d: got %h/%b expected %h/1", i, g_q, g_out_valid, exp[i]); end
            n_tests++; if (g_bit_out !== exp[i][0]) begin n_fail++; $display("FAIL galois_bit%0d: got %b expected %b", i, g_bit_out, exp[i][0]); end
        end
    endtask

    task automatic test_period();
        int wraps = 0;
        int wrap_at = -1;
        logic [7:0] q_at = 8'h00;
        for (int x = 6; x <= 257; x++) begin
            step();
            if (g_wrap === 1'b1) begin
                wraps++;
                if (wrap_at < 0) begin wrap_at = x; q_at = g_q; end
            end
        end
        n_tests++; if (wraps !== 1) begin n_fail++; $display("FAIL period_wrap_count: got %0d expected 1", wraps); end
        n_tests++; if (wrap_at !== 255) begin n_fail++; $display("FAIL period_wrap_at: got %0d expected 255", wrap_at); end
        n_tests++; if (q_at !== 8'h01) begin n_fail++; $display("FAIL period_wrap_q: got %h expected 01", q_at); end
        n_tests++; if (g_period !== 8'd255 || g_period_valid !== 1'b1) begin n_fail++; $display("FAIL period_value: got %0d/%b expected 255/1", g_period, g_period_valid); end
        n_tests++; if (g_q !== 8'h5C) begin n_fail++; $display("FAIL period_resume_q: got %h expected 5c", g_q); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++; if (g_q !== 8'h5C || g_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d: got %h/%b expected 5c/1", i, g_q, g_out_valid); end
            if (i == 1) en = 1'b0;
            if (i == 3) en = 1'b1;
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (g_q !== 8'h2E || g_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %h/%b expected 2e/1", g_q, g_out_valid); end
        step();
        n_tests++; if (g_q !== 8'h17) begin n_fail++; $display("FAIL stall_next: got %h expected 17", g_q); end
    endtask

    task automatic test_load();
        int wrap_at = -1;
        logic [7:0] q_at = 8'h00;
        load = 1'b1; seed_in = 8'h00;
        step();
        load = 1'b0;
        n_tests++; if (g_q !== 8'h01 || g_out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_load_q: got %h/%b expected 01/0", g_q, g_out_valid); end
        n_tests++; if (g_seed_err !== 1'b1 || g_wrap !== 1'b0) begin n_fail++; $display("FAIL zero_load_err: got %b/%b expected 1/0", g_seed_err, g_wrap); end
        n_tests++; if (g_period !== 8'h00 || g_period_valid !== 1'b0) begin n_fail++; $display("FAIL zero_load_period: got %h/%b expected 00/0", g_period, g_period_valid); end
        step();
        n_tests++; if (g_seed_err !== 1'b0 || g_out_valid !== 1'b1 || g_q !== 8'h01) begin n_fail++; $display("FAIL zero_load_after: got %b/%b/%h expected 0/1/01", g_seed_err, g_out_valid, g_q); end
        load = 1'b1; seed_in = 8'h5C;
        step();
        load = 1'b0;
        n_tests++; if (g_q !== 8'h5C || g_out_valid !== 1'b0 || g_seed_err !== 1'b0) begin n_fail++; $display("FAIL seed_load: got %h/%b/%b expected 5c/0/0", g_q, g_out_valid, g_seed_err); end
        step();
        n_tests++; if (g_q !== 8'h5C || g_out_valid !== 1'b1) begin n_fail++; $display("FAIL seed_first: got %h/%b expected 5c/1", g_q, g_out_valid); end
        for (int x = 1; x <= 256; x++) begin
            step();
            if (g_wrap === 1'b1 && wrap_at < 0) begin wrap_at = x; q_at = g_q; end
        end
        n_tests++; if (wrap_at !== 255 || q_at !== 8'h5C) begin n_fail++; $display("FAIL seed_wrap: got %0d/%h expected 255/5c", wrap_at, q_at); end
        n_tests++; if (g_period !== 8'd255 || g_period_valid !== 1'b1) begin n_fail++; $display("FAIL seed_period: got %0d/%b expected 255/1", g_period, g_period_valid); end
    endtask

    task automatic test_fibonacci();
        logic [7:0] exp [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        int wrap_at = -1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++; if (f_q !== exp[i] || f_out_valid !== 1'b1) begin n_fail++; $display("FAIL fib_word%0d: got %h/%b expected %h/1", i, f_q, f_out_valid, exp[i]); end
        end
        for (int x = 6; x <= 256; x++) begin
            step();
            if (f_wrap === 1'b1 && wrap_at < 0) wrap_at = x;
        end
        n_tests++; if (wrap_at !== 255) begin n_fail++; $display("FAIL fib_wrap_at: got %0d expected 255", wrap_at); end
        n_tests++; if (f_period !== 8'd255 || f_period_valid !== 1'b1) begin n_fail++; $display("FAIL fib_period: got %0d/%b expected 255/1", f_period, f_period_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 37; i++) step();
        #2;
        n_tests++; if (g_period_valid !== 1'b1 || g_out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got %b/%b expected 1/1", g_period_valid, g_out_valid); end
        reset = 1'b1;
        #1;
        n_tests++; if (g_q !== 8'h01 || g_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_q: got %h/%b expected 01/0", g_q, g_out_valid); end
        n_tests++; if (g_period !== 8'h00 || g_period_valid !== 1'b0) begin n_fail++; $display("FAIL async_period: got %h/%b expected 00/0", g_period, g_period_valid); end
        n_tests++; if (f_q !== 8'h01 || f_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_fib: got %h/%b expected 01/0", f_q, f_out_valid); end
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_galois_seq();
        test_period();
        test_backpressure();
        test_load();
        test_fibonacci();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
